// File: rtl/vfree_list.sv
// Circular free list of vector physical register IDs feeding the rename-stage aliasing table.
// Head is show-ahead; commit returns superseded IDs at the tail, and in_list blocks duplicate releases.
module vfree_list #(
  parameter int P_REGS     = 16,
  parameter int RESERVED   = 8,
  parameter int DATA_WIDTH = $clog2(P_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reconfigure,
  input  logic                        alloc_req,
  output logic                        alloc_valid,
  output logic [DATA_WIDTH-1:0]       alloc_id,
  input  logic                        release_en,
  input  logic [DATA_WIDTH-1:0]       release_id,
  output logic [$clog2(P_REGS+1)-1:0] free_count,
  output logic                        empty,
  output logic                        full,
  output logic                        err_double,
  output logic                        err_underflow
);

  localparam int CW = $clog2(P_REGS+1);

  logic [DATA_WIDTH-1:0] slots [P_REGS];
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [CW-1:0]         count;
  logic [P_REGS-1:0]     in_list;
  logic                  pop;
  logic                  accept;

  always_comb begin
    empty       = (count == '0);
    full        = (count == CW'(P_REGS));
    alloc_valid = ~empty;
    alloc_id    = slots[head];
    free_count  = count;
    pop         = alloc_req & ~empty;
    // in_list is read before this cycle's pop clears it, so re-releasing the popped ID is a double
    accept      = release_en & ~in_list[release_id];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Slots beyond the free region are never read before being overwritten by a release
      for (int k = 0; k < P_REGS; k++) begin
        slots[k]   <= DATA_WIDTH'((k + RESERVED) % P_REGS);
        in_list[k] <= (k >= RESERVED);
      end
      head          <= '0;
      tail          <= DATA_WIDTH'(P_REGS - RESERVED);
      count         <= CW'(P_REGS - RESERVED);
      err_double    <= 1'b0;
      err_underflow <= 1'b0;
    end else if (reconfigure) begin
      for (int k = 0; k < P_REGS; k++) begin
        slots[k] <= DATA_WIDTH'(k);
      end
      head    <= '0;
      tail    <= '0;
      count   <= CW'(P_REGS);
      in_list <= '1;
    end else begin
      if (alloc_req && empty) begin
        err_underflow <= 1'b1;
      end
      if (release_en && in_list[release_id]) begin
        err_double <= 1'b1;
      end
      if (pop) begin
        head              <= head + DATA_WIDTH'(1);
        in_list[alloc_id] <= 1'b0;
      end
      if (accept) begin
        slots[tail]         <= release_id;
        tail                <= tail + DATA_WIDTH'(1);
        in_list[release_id] <= 1'b1;
      end
      if (pop && !accept) begin
        count <= count - CW'(1);
      end else if (accept && !pop) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vfree_list.sv
// Self-checking bench for vfree_list: directed vector table, hand-written wrap/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_vfree_list;

  localparam int P_REGS   = 16;
  localparam int RESERVED = 8;
  localparam int DW       = $clog2(P_REGS);
  localparam int CW       = $clog2(P_REGS+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reconfigure = 1'b0;
  logic          alloc_req = 1'b0;
  logic          alloc_valid;
  logic [DW-1:0] alloc_id;
  logic          release_en = 1'b0;
  logic [DW-1:0] release_id = '0;
  logic [CW-1:0] free_count;
  logic          empty;
  logic          full;
  logic          err_double;
  logic          err_underflow;

  int testCount = 0;
  int failCount = 0;

  // Reference model: the free list as an ordered queue of IDs plus sticky flags
  int mq[$];
  bit mErrDouble;
  bit mErrUnderflow;

  typedef struct {
    string name;
    bit    r;
    bit    rc;
    bit    a;
    bit    re;
    int    rid;
    bit    ev;
    int    eid;
    int    ecnt;
    bit    eed;
    bit    eeu;
  } vec_t;

  vec_t vecs[$];

  vfree_list #(.P_REGS(P_REGS), .RESERVED(RESERVED)) dut (
    .clk(clk),
    .rst(rst),
    .reconfigure(reconfigure),
    .alloc_req(alloc_req),
    .alloc_valid(alloc_valid),
    .alloc_id(alloc_id),
    .release_en(release_en),
    .release_id(release_id),
    .free_count(free_count),
    .empty(empty),
    .full(full),
    .err_double(err_double),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic bit inModel(int id);
    foreach (mq[i]) if (mq[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelStep(input bit r, input bit rc, input bit a, input bit re, input int rid);
    bit accept;
    if (r) begin
      mq.delete();
      for (int i = RESERVED; i < P_REGS; i++) mq.push_back(i);
      mErrDouble    = 1'b0;
      mErrUnderflow = 1'b0;
    end else if (rc) begin
      mq.delete();
      for (int i = 0; i < P_REGS; i++) mq.push_back(i);
    end else begin
      accept = re && !inModel(rid);
      if (re && !accept) mErrDouble = 1'b1;
      if (a && mq.size() == 0) mErrUnderflow = 1'b1;
      if (a && mq.size() > 0) void'(mq.pop_front());
      if (accept) mq.push_back(rid);
    end
  endtask

  function automatic void addVec(string name, bit r, bit rc, bit a, bit re, int rid,
                                 bit ev, int eid, int ecnt, bit eed, bit eeu);
    vec_t v;
    v.name = name; v.r = r; v.rc = rc; v.a = a; v.re = re; v.rid = rid;
    v.ev = ev; v.eid = eid; v.ecnt = ecnt; v.eed = eed; v.eeu = eeu;
    vecs.push_back(v);
  endfunction

  task automatic cmpVal(input string nm, input int act, input int exp);
    testCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample just after the edge
  task automatic applyStimulus(input bit r, input bit rc, input bit a, input bit re, input int rid);
    rst         = r;
    reconfigure = rc;
    alloc_req   = a;
    release_en  = re;
    release_id  = DW'(rid);
    modelStep(r, rc, a, re, rid);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit ev, input int eid, input int ecnt,
                             input bit eed, input bit eeu);
    cmpVal({name, ".alloc_valid"}, int'(alloc_valid), int'(ev));
    if (ev) cmpVal({name, ".alloc_id"}, int'(alloc_id), eid);
    cmpVal({name, ".free_count"}, int'(free_count), ecnt);
    cmpVal({name, ".empty"}, int'(empty), int'(ecnt == 0));
    cmpVal({name, ".full"}, int'(full), int'(ecnt == P_REGS));
    cmpVal({name, ".err_double"}, int'(err_double), int'(eed));
    cmpVal({name, ".err_underflow"}, int'(err_underflow), int'(eeu));
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mq.size() > 0, (mq.size() > 0) ? mq[0] : 0, mq.size(),
                mErrDouble, mErrUnderflow);
  endtask

  initial begin
    // Directed table: reset, drain, empty+release, reconfigure, double release, pop+release
    addVec("reset", 1, 0, 0, 0, 0, 1, 8, 8, 0, 0);
    for (int k = 1; k <= 8; k++)
      addVec($sformatf("drain%0d", k), 0, 0, 1, 0, 0, k < 8, 8 + k, 8 - k, 0, 0);
    addVec("empty_alloc_rel3", 0, 0, 1, 1, 3, 1, 3, 1, 0, 1);
    addVec("reconf", 0, 1, 1, 1, 5, 1, 0, 16, 0, 1);
    for (int k = 1; k <= 16; k++)
      addVec($sformatf("pop16_%0d", k), 0, 0, 1, 0, 0, k < 16, k, 16 - k, 0, 1);
    addVec("reset2", 1, 0, 0, 0, 0, 1, 8, 8, 0, 0);
    addVec("double_rel9", 0, 0, 0, 1, 9, 1, 8, 8, 1, 0);
    addVec("pop8", 0, 0, 1, 0, 0, 1, 9, 7, 1, 0);
    addVec("pop9", 0, 0, 1, 0, 0, 1, 10, 6, 1, 0);
    addVec("pop10_rel2", 0, 0, 1, 1, 2, 1, 11, 6, 1, 0);
    addVec("pop11_rel11", 0, 0, 1, 1, 11, 1, 12, 5, 1, 0);

    mq.delete();
    mErrDouble = 1'b0;
    mErrUnderflow = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].rc, vecs[i].a, vecs[i].re, vecs[i].rid);
      checkOutput(vecs[i].name, vecs[i].ev, vecs[i].eid, vecs[i].ecnt, vecs[i].eed, vecs[i].eeu);
    end

    // Wrap: pop then return the same ID, so the tail crosses index 15 -> 0
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("wrap_reset", 1, 8, 8, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput($sformatf("wrap_pop%0d", i), 1, 8 + ((i + 1) % 8), 7, 0, 0);
      applyStimulus(0, 0, 0, 1, 8 + (i % 8));
      checkOutput($sformatf("wrap_rel%0d", i), 1, 8 + ((i + 1) % 8), 8, 0, 0);
    end

    // Mid-stream reset with free_count=3 and a sticky error set
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 13);
    checkOutput("pre_midrst", 1, 13, 3, 1, 0);
    applyStimulus(1, 0, 1, 1, 2);
    checkOutput("midrst", 1, 8, 8, 0, 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      bit r, rc, a, re;
      int rid;
      r   = ($urandom_range(99, 0) == 0);
      rc  = ($urandom_range(59, 0) == 0);
      a   = ($urandom_range(99, 0) < 45);
      re  = ($urandom_range(99, 0) < 55);
      rid = $urandom_range(P_REGS - 1, 0);
      applyStimulus(r, rc, a, re, rid);
      checkModel($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
